// File: rtl/seg_display_ctrl.sv
// Display-source controller: arbitrates the 4-digit BCD bus between the switch operand
// and a GCD result converted by a sequential double-dabble engine, with a minimum hold.
module seg_display_ctrl #(
  parameter int unsigned HOLD_CYCLES = 100000000,
  parameter bit          LZ_BLANK    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic [1:0]  cpu_state,
  input  logic        res_valid,
  input  logic [31:0] res_data,
  output logic        res_ready,
  input  logic        clear,
  output logic [15:0] seg_data_16,
  output logic [1:0]  disp_src,
  output logic        conv_busy,
  output logic        overflow
);

  typedef enum logic [1:0] {StShowIn, StConvert, StShowRes} state_e;

  localparam logic [26:0] HoldInit  = 27'(HOLD_CYCLES - 1);
  localparam logic [3:0]  LastIter  = 4'd13;

  state_e      state_q, state_d;
  logic [13:0] sh_q, sh_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  iter_q, iter_d;
  logic        sat_q, sat_d;
  logic [26:0] hold_q, hold_d;
  logic [15:0] seg_q, seg_d;
  logic [1:0]  src_q, src_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;

  logic        accept;
  logic [15:0] bcd_adj, bcd_step, commit_raw, commit_val;

  assign res_ready = (state_q != StConvert) & ~clear;
  assign accept    = res_valid & res_ready;

  // One double-dabble step: add-3 correction per nibble, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_step   = {bcd_adj[14:0], sh_q[13]};
    commit_raw = sat_q ? 16'h9999 : bcd_step;
    commit_val = commit_raw;
    if (LZ_BLANK && commit_raw[15:12] == 4'd0) begin
      commit_val[15:12] = 4'hF;
      if (commit_raw[11:8] == 4'd0) begin
        commit_val[11:8] = 4'hF;
        if (commit_raw[7:4] == 4'd0) commit_val[7:4] = 4'hF;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    sat_d   = sat_q;
    hold_d  = hold_q;
    seg_d   = seg_q;
    src_d   = src_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = StShowIn;
      seg_d   = in_data;
      src_d   = 2'd0;
      busy_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      // Only 14 bits feed the engine; out-of-range values are flagged and shown as 9999.
      state_d = StConvert;
      sh_d    = res_data[13:0];
      bcd_d   = 16'd0;
      iter_d  = 4'd0;
      sat_d   = res_data > 32'd9999;
      busy_d  = 1'b1;
      src_d   = 2'd2;
    end else begin
      unique case (state_q)
        StShowIn: seg_d = in_data;
        StConvert: begin
          sh_d   = {sh_q[12:0], 1'b0};
          bcd_d  = bcd_step;
          iter_d = iter_q + 4'd1;
          if (iter_q == LastIter) begin
            state_d = StShowRes;
            seg_d   = commit_val;
            ovf_d   = sat_q;
            busy_d  = 1'b0;
            src_d   = 2'd1;
            hold_d  = HoldInit;
          end
        end
        StShowRes: begin
          if (hold_q != 27'd0) begin
            hold_d = hold_q - 27'd1;
          end else if (cpu_state == 2'd0) begin
            state_d = StShowIn;
            seg_d   = in_data;
            src_d   = 2'd0;
          end
        end
        default: state_d = StShowIn;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StShowIn;
      sh_q    <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      sat_q   <= 1'b0;
      hold_q  <= '0;
      seg_q   <= 16'hFFFF;
      src_q   <= 2'd0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
      sat_q   <= sat_d;
      hold_q  <= hold_d;
      seg_q   <= seg_d;
      src_q   <= src_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign seg_data_16 = seg_q;
  assign disp_src    = src_q;
  assign conv_busy   = busy_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: expected digits are queued at accept time
// from a decimal reference model and compared when the conversion commits.
module tb_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic [1:0]  cpu_state;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready;
  logic        clear;
  logic [15:0] seg_data_16;
  logic [1:0]  disp_src;
  logic        conv_busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_seg_q[$];
  logic        exp_ovf_q[$];
  logic [15:0] prev_seg;

  seg_display_ctrl #(
    .HOLD_CYCLES(8),
    .LZ_BLANK   (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .cpu_state  (cpu_state),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .clear      (clear),
    .seg_data_16(seg_data_16),
    .disp_src   (disp_src),
    .conv_busy  (conv_busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decimal reference: saturate above 9999, blank leading zeros in digits 3..1.
  function automatic logic [15:0] model_seg(input logic [31:0] v);
    logic [15:0] d;
    int unsigned x;
    if (v > 32'd9999) return 16'h9999;
    x = v;
    d = {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
    if (d[15:12] == 4'd0) begin
      d[15:12] = 4'hF;
      if (d[11:8] == 4'd0) begin
        d[11:8] = 4'hF;
        if (d[7:4] == 4'd0) d[7:4] = 4'hF;
      end
    end
    return d;
  endfunction

  task automatic do_accept(input logic [31:0] v, input bit keep);
    prev_seg  = seg_data_16;
    res_data  = v;
    res_valid = 1'b1;
    checks++;
    if (res_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: res_ready=%b required 1", res_ready);
    end
    tick();
    res_valid = 1'b0;
    if (keep) begin
      exp_seg_q.push_back(model_seg(v));
      exp_ovf_q.push_back(v > 32'd9999);
    end
    checks++;
    if (conv_busy !== 1'b1 || disp_src !== 2'd2) begin
      errors++;
      $display("FAIL accept_e0: busy=%b src=%0d required busy=1 src=2", conv_busy, disp_src);
    end
  endtask

  task automatic wait_commit(input string name);
    int n = 0;
    bit held = 1'b1;
    logic [15:0] es;
    logic        eo;
    while (conv_busy === 1'b1 && n < 40) begin
      if (res_ready !== 1'b0 || seg_data_16 !== prev_seg) held = 1'b0;
      tick();
      n++;
    end
    checks++;
    if (n != 14) begin
      errors++;
      $display("FAIL %s_latency: busy cycles=%0d required 14", name, n);
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL %s_during_conv: res_ready or digits changed, required ready=0 seg=%h",
               name, prev_seg);
    end
    checks++;
    if (exp_seg_q.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: commit with empty queue, seg=%h", name, seg_data_16);
    end else begin
      es = exp_seg_q.pop_front();
      eo = exp_ovf_q.pop_front();
      if (seg_data_16 !== es || overflow !== eo || disp_src !== 2'd1 || res_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s_commit: seg=%h ovf=%b src=%0d ready=%b required seg=%h ovf=%b src=1 ready=1",
                 name, seg_data_16, overflow, disp_src, res_ready, es, eo);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_data = 16'h1234;
    cpu_state = 2'd0;
    res_valid = 1'b0;
    res_data = '0;
    clear = 1'b0;
    #1 rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (seg_data_16 !== 16'hFFFF || res_ready !== 1'b1 || overflow !== 1'b0 ||
        disp_src !== 2'd0 || conv_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: seg=%h ready=%b ovf=%b src=%0d busy=%b required FFFF 1 0 0 0",
               seg_data_16, res_ready, overflow, disp_src, conv_busy);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (seg_data_16 !== 16'h1234) begin
      errors++;
      $display("FAIL reset_release: seg=%h required 1234", seg_data_16);
    end
  endtask

  task automatic test_convert();
    cpu_state = 2'd2;
    do_accept(32'd21, 1'b1);
    wait_commit("conv21");
  endtask

  task automatic test_overflow();
    do_accept(32'd12345, 1'b1);
    wait_commit("conv12345");
  endtask

  task automatic test_back_to_back();
    do_accept(32'd0, 1'b1);
    wait_commit("conv0");
    do_accept(32'd9999, 1'b1);
    wait_commit("conv9999");
  endtask

  task automatic test_hold_return();
    int n = 0;
    cpu_state = 2'd0;
    in_data = 16'h4321;
    do_accept(32'd7, 1'b1);
    wait_commit("hold7");
    while (disp_src === 2'd1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n != 8 || seg_data_16 !== 16'h4321) begin
      errors++;
      $display("FAIL hold_return: cycles=%0d seg=%h required 8 4321", n, seg_data_16);
    end
    in_data = 16'h5678;
    tick();
    checks++;
    if (seg_data_16 !== 16'h5678 || disp_src !== 2'd0) begin
      errors++;
      $display("FAIL operand_follow: seg=%h src=%0d required 5678 0", seg_data_16, disp_src);
    end
  endtask

  task automatic test_hold_cpu_busy();
    bit stay = 1'b1;
    cpu_state = 2'd2;
    do_accept(32'd7, 1'b1);
    wait_commit("busy7");
    for (int i = 0; i < 100; i++) begin
      tick();
      if (disp_src !== 2'd1 || seg_data_16 !== 16'hFFF7) stay = 1'b0;
    end
    checks++;
    if (!stay) begin
      errors++;
      $display("FAIL hold_cpu_busy: src=%0d seg=%h required 1 FFF7", disp_src, seg_data_16);
    end
    cpu_state = 2'd0;
    tick();
    checks++;
    if (disp_src !== 2'd0 || seg_data_16 !== 16'h5678) begin
      errors++;
      $display("FAIL cpu_idle_return: src=%0d seg=%h required 0 5678", disp_src, seg_data_16);
    end
  endtask

  task automatic test_clear();
    do_accept(32'd50000, 1'b1);
    wait_commit("conv50000");
    do_accept(32'd42, 1'b0);
    repeat (4) tick();
    clear = 1'b1;
    res_valid = 1'b1;
    res_data = 32'd55;
    checks++;
    if (res_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_ready: res_ready=%b required 0", res_ready);
    end
    tick();
    clear = 1'b0;
    res_valid = 1'b0;
    checks++;
    if (conv_busy !== 1'b0 || disp_src !== 2'd0 || seg_data_16 !== 16'h5678 ||
        overflow !== 1'b0) begin
      errors++;
      $display("FAIL clear_effect: busy=%b src=%0d seg=%h ovf=%b required 0 0 5678 0",
               conv_busy, disp_src, seg_data_16, overflow);
    end
    tick();
    checks++;
    if (conv_busy !== 1'b0 || disp_src !== 2'd0 || res_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_not_accepted: busy=%b src=%0d ready=%b required 0 0 1",
               conv_busy, disp_src, res_ready);
    end
  endtask

  task automatic test_reset_mid_conv();
    do_accept(32'd1234, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (seg_data_16 !== 16'hFFFF || conv_busy !== 1'b0 || disp_src !== 2'd0 ||
        res_ready !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_conv: seg=%h busy=%b src=%0d ready=%b ovf=%b required FFFF 0 0 1 0",
               seg_data_16, conv_busy, disp_src, res_ready, overflow);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (seg_data_16 !== 16'h5678 || conv_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_recover: seg=%h busy=%b required 5678 0", seg_data_16, conv_busy);
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_overflow();
    test_back_to_back();
    test_hold_return();
    test_hold_cpu_busy();
    test_clear();
    test_reset_mid_conv();
    checks++;
    if (exp_seg_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_seg_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
